// File: rtl/sargantana_set_ram_ctrl.sv
// Set-RAM port controller: arbitrates fetch reads, refill writes
// and a zero-fill flush sweep onto one single-port set RAM.
module sargantana_set_ram_ctrl #(
   parameter int ICACHE_DEPTH = 64,
   parameter int SET_WIDHT    = 32*8,
   parameter int ADDR_WIDHT   = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  flush_done_o,
   input  logic                  rd_req_i,
   input  logic [ADDR_WIDHT-1:0] rd_addr_i,
   output logic                  rd_gnt_o,
   output logic                  rd_valid_o,
   output logic [SET_WIDHT-1:0]  rd_data_o,
   input  logic                  wr_req_i,
   input  logic [ADDR_WIDHT-1:0] wr_addr_i,
   input  logic [SET_WIDHT-1:0]  wr_data_i,
   output logic                  wr_gnt_o,
   output logic                  ram_req_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDHT-1:0] ram_addr_o,
   output logic [SET_WIDHT-1:0]  ram_data_o,
   input  logic [SET_WIDHT-1:0]  ram_data_i
);

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      DONE
   } state_t;

   localparam logic [ADDR_WIDHT-1:0] LAST =
      ADDR_WIDHT'(ICACHE_DEPTH - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDHT-1:0] cnt_q, cnt_d;
   logic                  rd_valid_q, rd_valid_d;

   // State, sweep counter and read-valid registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Next state, arbitration and RAM-side drive
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ram_req_o    = 1'b0;
      ram_we_o     = 1'b0;
      ram_addr_o   = '0;
      ram_data_o   = '0;
      rd_gnt_o     = 1'b0;
      wr_gnt_o     = 1'b0;
      flush_done_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush_i) begin
               state_d = FLUSH;
            end else if (wr_req_i) begin
               ram_req_o  = 1'b1;
               ram_we_o   = 1'b1;
               ram_addr_o = wr_addr_i;
               ram_data_o = wr_data_i;
               wr_gnt_o   = 1'b1;
            end else if (rd_req_i) begin
               ram_req_o  = 1'b1;
               ram_addr_o = rd_addr_i;
               rd_gnt_o   = 1'b1;
            end
         end
         FLUSH: begin
            ram_req_o  = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = cnt_q;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            flush_done_o = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Read data is only presented alongside its valid strobe
   always_comb begin
      rd_valid_d = rd_gnt_o;
      busy_o     = (state_q != IDLE);
      rd_valid_o = rd_valid_q;
      rd_data_o  = rd_valid_q ? ram_data_i : '0;
   end

endmodule
